dmem_arbiter: RTL

Two-port arbiter and access sequencer for the single-port, byte-addressed, word-granular data memory. It shares the memory between the pipeline MEM-stage port (A) and a loader/DMA port (B) using round-robin arbitration with a bounded lock for B bursts. Each access runs through a three-state FSM that drives the memory's address, data and read/write strobes. Read data is captured into a per-port response register. The block sits between the MEM stage / loader and the data memory; the MEM stage stalls on `req_a && !ack_a`.

---
 rtl/dmem_arbiter.sv | 131 +++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and IDLE/ACCESS/RESP sequencer that shares the single-port
// data memory between the MEM-stage port (A) and the loader/DMA port (B).
module dmem_arbiter #(
   parameter int ADDR_W   = 64,
   parameter int DATA_W   = 64,
   parameter int MAX_LOCK = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_a,
   input  logic              we_a,
   input  logic [ADDR_W-1:0] addr_a,
   input  logic [DATA_W-1:0] wdata_a,
   input  logic              req_b,
   input  logic              we_b,
   input  logic [ADDR_W-1:0] addr_b,
   input  logic [DATA_W-1:0] wdata_b,
   input  logic              lock_b,
   output logic              ack_a,
   output logic              err_a,
   output logic [DATA_W-1:0] rdata_a,
   output logic              ack_b,
   output logic              err_b,
   output logic [DATA_W-1:0] rdata_b,
   input  logic [31:0]       mem_rdata,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_write,
   output logic              mem_read
);

   // state    | meaning
   // S_IDLE   | waiting for a request; grant and latch the winning access
   // S_ACCESS | strobes driven for one cycle; read data captured at its end
   // S_RESP   | owner's ack/err pulse; rr and lock counter updated
   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

   state_t              state_q, state_d;
   logic                owner_q, owner_d;     // 0 = A, 1 = B
   logic                rr_q, rr_d;           // preferred port on contention
   logic [3:0]          lock_cnt_q, lock_cnt_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [DATA_W-1:0]   rdata_a_q, rdata_a_d;
   logic [DATA_W-1:0]   rdata_b_q, rdata_b_d;

   logic aligned;
   logic grant_b;

   assign aligned = (addr_q[1:0] == 2'b00);

   // B keeps ownership while its lock is honoured, otherwise rr breaks ties
   assign grant_b = req_b &
                    (!req_a |
                     (owner_q & lock_b & (lock_cnt_q < 4'(MAX_LOCK))) |
                     rr_q);

   always_comb begin
      state_d    = state_q;
      owner_d    = owner_q;
      rr_d       = rr_q;
      lock_cnt_d = lock_cnt_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      rdata_a_d  = rdata_a_q;
      rdata_b_d  = rdata_b_q;
      case (state_q)
         S_IDLE: begin
            if (req_a || req_b) begin
               owner_d = grant_b;
               we_d    = grant_b ? we_b    : we_a;
               addr_d  = grant_b ? addr_b  : addr_a;
               wdata_d = grant_b ? wdata_b : wdata_a;
               state_d = S_ACCESS;
            end
         end
         S_ACCESS: begin
            if (!we_q && aligned) begin
               if (owner_q) rdata_b_d = {{(DATA_W-32){1'b0}}, mem_rdata};
               else         rdata_a_d = {{(DATA_W-32){1'b0}}, mem_rdata};
            end
            state_d = S_RESP;
         end
         S_RESP: begin
            rr_d       = !owner_q;
            lock_cnt_d = (owner_q && lock_b && req_a) ? lock_cnt_q + 4'd1 : 4'd0;
            state_d    = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         owner_q    <= 1'b0;
         rr_q       <= 1'b0;
         lock_cnt_q <= 4'd0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         rdata_a_q  <= '0;
         rdata_b_q  <= '0;
      end else begin
         state_q    <= state_d;
         owner_q    <= owner_d;
         rr_q       <= rr_d;
         lock_cnt_q <= lock_cnt_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         rdata_a_q  <= rdata_a_d;
         rdata_b_q  <= rdata_b_d;
      end
   end

   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign mem_write = (state_q == S_ACCESS) &&  we_q && aligned;
   assign mem_read  = (state_q == S_ACCESS) && !we_q && aligned;

   assign ack_a   = (state_q == S_RESP) && !owner_q;
   assign ack_b   = (state_q == S_RESP) &&  owner_q;
   assign err_a   = ack_a && !aligned;
   assign err_b   = ack_b && !aligned;
   assign rdata_a = rdata_a_q;
   assign rdata_b = rdata_b_q;

endmodule
